mem_edit_ctrl: RTL and testbench
================================

Name: mem_edit_ctrl

Overview:
- Sequencing controller for the 16x8 synchronous RAM editor, replacing the ad-hoc edge-detect controller.
- Synchronises and debounces the four active-low pushbuttons and turns each press into exactly one command.
- Commands are address increment, address decrement, data increment and data decrement.
- Runs the RAM's one-cycle-latency read-modify-write as an explicit FSM, so each press changes the data by exactly one, never zero or two.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive identical synchronised samples required before a key level is accepted (20 ms at 50 MHz)
AW, 4, RAM address width
DW, 8, RAM data width

Ports:
clk    input   1    system clock (CLOCK_50 at the top level)
reset  input   1    synchronous, active-high reset
KEY    input   4    raw pushbuttons, active-low; KEY[0] = data decrement, KEY[1] = data increment, KEY[2] = address decrement, KEY[3] = address increment
dout   input   DW   RAM read data; registered in the RAM, reflects mem[a] one cycle after a is sampled
a      output  AW   RAM address, registered
din    output  DW   RAM write data, registered
we     output  1    RAM write enable, registered
busy   output  1    high while a read-modify-write is in progress

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset. All state updates on posedge clk.
- Reset values: a=0, din=0, we=0, busy=0, FSM=IDLE. Synchroniser flops=1 and debounced levels=1 (released). Debounce counters=0.
- Synchroniser: 2-flop synchroniser per KEY bit.
- Debounce:
  - Per key, a counter increments while the synchronised sample differs from the debounced level.
  - The counter clears when the sample matches the debounced level.
  - On reaching DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Press pulse: one-cycle pulse when a debounced level goes 1->0. Releases generate nothing.
- Arbitration:
  - Pulses are considered only in IDLE.
  - With simultaneous pulses, the lowest KEY index wins; the others are dropped.
  - Pulses arriving while not in IDLE are dropped, not queued.
- FSM states: IDLE, RD, WR.
  - IDLE + KEY3 pulse: a <= a+1, modulo 2^AW (15 -> 0). Stay in IDLE.
  - IDLE + KEY2 pulse: a <= a-1, modulo 2^AW (0 -> 15). Stay in IDLE.
  - IDLE + KEY1 or KEY0 pulse: latch the operation, go to RD, busy <= 1. a is held.
  - RD: lasts 1 cycle. At its end, din <= dout+1 (inc) or dout-1 (dec), modulo 2^DW (FF+1 = 00, 00-1 = FF). we <= 1. Go to WR.
  - WR: lasts 1 cycle, with we=1 and din stable. At its end, we <= 0, busy <= 0, go to IDLE.
- Data-press latency: press pulse to we high is 2 cycles; we is high for exactly 1 cycle.
- a never changes while busy=1.
- Read correctness:
  - dout captured in RD always reflects any write from a preceding WR, because at least one IDLE cycle separates WR and the next RD.
  - An address change in IDLE is at least 1 cycle old before any RD capture.
- Reset mid-operation:
  - If reset is asserted in the WR cycle, the RAM still sees we=1 at that edge, so the write completes.
  - Outputs return to reset values on the following cycle.
  - If reset is asserted in RD, no write occurs.
- Held key: produces one command only; no auto-repeat.

Decomposition:
- Package mem_edit_pkg:
  - state_t enum {IDLE, RD, WR}
  - op_t enum {OP_NONE, OP_AINC, OP_ADEC, OP_DINC, OP_DDEC}
  - AW and DW default constants
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES):
  - Contains the 2-flop synchroniser, counter and level register for one key.
  - Outputs the debounced level and the press pulse.
  - mem_edit_ctrl instantiates it 4 times.
  - Counter width is $clog2(DEBOUNCE_CYCLES).

Test Plan:
- Run with DEBOUNCE_CYCLES=4; after reset, press KEY3 cleanly three times -> a = 3, we never asserted.
- a=0; press KEY2 -> a=15. Repeat from a=15 with KEY3 -> a=0 (address wrap both ways).
- Memory model with mem[5]=8'hFF, a=5; press KEY1 -> exactly 2 cycles after the press pulse, we=1 for one cycle with din=8'h00. Then press KEY0 twice -> mem[5]=8'hFE.
- KEY toggling for 3 cycles between 0 and 1, then held high -> no pulse, no state change. Held low for 10 cycles -> exactly one command.
- KEY0 and KEY3 falling in the same cycle -> only the data decrement executes and a is unchanged. KEY3 pressed during busy -> dropped.
- Reset asserted in the WR cycle -> the write lands in memory. Next cycle we=0, busy=0, a=0, din=0, FSM=IDLE.

Source files
------------

// File: rtl/mem_edit_ctrl_pkg.sv
// Shared types and default widths for the RAM editor controller.
package mem_edit_pkg;

   localparam int AW_DEFAULT = 4;
   localparam int DW_DEFAULT = 8;

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   typedef enum logic [2:0] {OP_NONE, OP_AINC, OP_ADEC, OP_DINC, OP_DDEC} op_t;

endpackage

// File: rtl/mem_edit_ctrl_if.sv
// RAM-side bus of the editor controller: address, write data/strobe, read data, busy.
interface mem_edit_ctrl_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   // No valid/ready here: we is a single-cycle write strobe qualified by a/din in the
   // same cycle, and dout is the RAM's registered read of the a sampled one edge earlier.
   logic [AW-1:0] a;
   logic [DW-1:0] din;
   logic          we;
   logic          busy;
   logic [DW-1:0] dout;

   modport master (output a, din, we, busy, input dout);
   modport slave  (input a, din, we, busy, output dout);
endinterface

// File: rtl/mem_edit_ctrl_key_debounce.sv
// One active-low pushbutton: 2-flop synchroniser, debounce counter and press pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // Level flips here; only the 1->0 direction is a press.
            level <= sync2;
            cnt   <= '0;
            press <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_edit_ctrl.sv
// Pushbutton-driven editor for a 16x8 synchronous RAM: address step and data +/-1 via RMW.
module mem_edit_ctrl
   import mem_edit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   KEY,
   mem_edit_ctrl_if.master bus,
   output logic [3:0]   key_level,
   output state_t       dbg_state
);

   logic [3:0] press;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .clk   (clk),
         .reset (reset),
         .key_n (KEY[k]),
         .level (key_level[k]),
         .press (press[k])
      );
   end

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] din_q, din_d;
   logic          we_q, we_d;
   logic          busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_NONE;
         a_q     <= '0;
         din_q   <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         din_q   <= din_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      din_d   = din_q;
      we_d    = we_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            // Lowest key index wins; the rest of a simultaneous set is dropped.
            if (press[0]) begin
               op_d    = OP_DDEC;
               state_d = RD;
               busy_d  = 1'b1;
            end else if (press[1]) begin
               op_d    = OP_DINC;
               state_d = RD;
               busy_d  = 1'b1;
            end else if (press[2]) begin
               a_d = a_q - 1'b1;
            end else if (press[3]) begin
               a_d = a_q + 1'b1;
            end
         end
         RD: begin
            din_d   = (op_q == OP_DINC) ? DW'(bus.dout + 1'b1) : DW'(bus.dout - 1'b1);
            we_d    = 1'b1;
            state_d = WR;
         end
         WR: begin
            we_d    = 1'b0;
            busy_d  = 1'b0;
            op_d    = OP_NONE;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.a     = a_q;
   assign bus.din   = din_q;
   assign bus.we    = we_q;
   assign bus.busy  = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_edit_ctrl.sv
// Bench for mem_edit_ctrl: RAM model, command-level reference model and write scoreboard.
module tb_mem_edit_ctrl;
   import mem_edit_pkg::*;

   localparam int DEB        = 4;
   localparam int AW         = 4;
   localparam int DW         = 8;
   // Posedges from driving a key low to the press pulse, and to we being high.
   localparam int PRESS_EDGE = 2 + DEB;
   localparam int WE_EDGE    = PRESS_EDGE + 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] KEY = 4'hF;
   logic [3:0] key_level;
   state_t     dbg_state;

   mem_edit_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   mem_edit_ctrl #(.DEBOUNCE_CYCLES(DEB), .AW(AW), .DW(DW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .KEY       (KEY),
      .bus       (bus),
      .key_level (key_level),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM model ----------------
   logic [DW-1:0] ram [16];
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_a = '0;
   logic [DW-1:0] pre_d = '0;

   always @(posedge clk) begin
      if (pre_en) ram[pre_a] <= pre_d;
      else if (bus.we) ram[bus.a] <= bus.din;
      bus.dout <= ram[bus.a];
   end

   // ---------------- reference model + scoreboard ----------------
   logic [DW-1:0]    ref_mem [16];
   logic [AW-1:0]    ref_a = '0;
   logic [AW+DW-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;
   int we_cnt = 0;
   int last_we_cyc = 0;
   logic [DW-1:0] last_we_din = '0;
   int t0 = 0;
   logic busy_prev = 1'b0;
   logic [AW-1:0] a_prev = '0;

   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         logic [AW+DW-1:0] e;
         we_cnt++;
         last_we_cyc = cyc;
         last_we_din = bus.din;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL write_unexpected: got a=%0d din=%02h, required no write", bus.a, bus.din);
         end else begin
            e = exp_q.pop_front();
            if ({bus.a, bus.din} !== e) begin
               fails++;
               $display("FAIL write_data: got a=%0d din=%02h, required a=%0d din=%02h",
                        bus.a, bus.din, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
      if (busy_prev && bus.busy === 1'b1) begin
         tests++;
         if (bus.a !== a_prev) begin
            fails++;
            $display("FAIL addr_stable_busy: got a=%0d, required a=%0d", bus.a, a_prev);
         end
      end
      busy_prev = (bus.busy === 1'b1);
      a_prev    = bus.a;
   end

   // One press of key idx is one command at the model level.
   task automatic model_cmd(input int idx);
      case (idx)
         3: ref_a = ref_a + 1'b1;
         2: ref_a = ref_a - 1'b1;
         1: begin
            ref_mem[ref_a] = ref_mem[ref_a] + 1'b1;
            exp_q.push_back({ref_a, ref_mem[ref_a]});
         end
         default: begin
            ref_mem[ref_a] = ref_mem[ref_a] - 1'b1;
            exp_q.push_back({ref_a, ref_mem[ref_a]});
         end
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      KEY   = 4'hF;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      ref_a = '0;
      @(negedge clk);
   endtask

   task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] val);
      @(negedge clk);
      pre_en = 1'b1;
      pre_a  = addr;
      pre_d  = val;
      ref_mem[addr] = val;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic press(input int idx, input int hold);
      @(negedge clk);
      KEY[idx] = 1'b0;
      t0 = cyc;
      model_cmd(idx);
      repeat (hold) @(negedge clk);
      KEY[idx] = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      tests += 6;
      if (bus.a !== 4'd0)   begin fails++; $display("FAIL reset_a: got %0d, required 0", bus.a); end
      if (bus.din !== 8'd0) begin fails++; $display("FAIL reset_din: got %02h, required 00", bus.din); end
      if (bus.we !== 1'b0)  begin fails++; $display("FAIL reset_we: got %b, required 0", bus.we); end
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
      if (key_level !== 4'hF) begin fails++; $display("FAIL reset_levels: got %h, required F", key_level); end
   endtask

   task automatic test_addr_inc();
      int w0;
      do_reset();
      w0 = we_cnt;
      repeat (3) press(3, 8);
      tests += 2;
      if (bus.a !== 4'd3) begin fails++; $display("FAIL addr_inc: got %0d, required 3", bus.a); end
      if (we_cnt !== w0)  begin fails++; $display("FAIL addr_inc_we: got %0d writes, required 0", we_cnt - w0); end
   endtask

   task automatic test_addr_wrap();
      do_reset();
      press(2, 8);
      tests++;
      if (bus.a !== 4'd15) begin fails++; $display("FAIL addr_wrap_down: got %0d, required 15", bus.a); end
      press(3, 8);
      tests++;
      if (bus.a !== 4'd0) begin fails++; $display("FAIL addr_wrap_up: got %0d, required 0", bus.a); end
   endtask

   task automatic test_data();
      int w0;
      preload(4'd5, 8'hFF);
      do_reset();
      repeat (5) press(3, 8);
      w0 = we_cnt;
      press(1, 10);
      tests += 3;
      if (we_cnt - w0 !== 1) begin fails++; $display("FAIL data_we_count: got %0d, required 1", we_cnt - w0); end
      if (last_we_cyc - t0 !== WE_EDGE) begin
         fails++; $display("FAIL data_latency: got %0d edges, required %0d", last_we_cyc - t0, WE_EDGE);
      end
      if (last_we_din !== 8'h00) begin fails++; $display("FAIL data_wrap_inc: got %02h, required 00", last_we_din); end
      press(0, 8);
      press(0, 8);
      tests += 2;
      if (ram[5] !== 8'hFE) begin fails++; $display("FAIL data_dec_twice: got %02h, required FE", ram[5]); end
      if (bus.a !== 4'd5)   begin fails++; $display("FAIL data_addr_held: got %0d, required 5", bus.a); end
   endtask

   task automatic test_bounce();
      int w0;
      w0 = we_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         KEY[3] = (i % 2 == 1);
      end
      repeat (15) @(negedge clk);
      tests += 2;
      if (bus.a !== ref_a) begin fails++; $display("FAIL bounce_addr: got %0d, required %0d", bus.a, ref_a); end
      if (we_cnt !== w0)   begin fails++; $display("FAIL bounce_we: got %0d writes, required 0", we_cnt - w0); end
      press(3, 10);
      tests++;
      if (bus.a !== ref_a) begin fails++; $display("FAIL held10_addr: got %0d, required %0d", bus.a, ref_a); end
      press(3, 30);
      tests++;
      if (bus.a !== ref_a) begin fails++; $display("FAIL no_repeat_addr: got %0d, required %0d", bus.a, ref_a); end
   endtask

   task automatic test_simultaneous();
      logic [AW-1:0] a0;
      a0 = ref_a;
      @(negedge clk);
      KEY[0] = 1'b0;
      KEY[3] = 1'b0;
      model_cmd(0);
      repeat (10) @(negedge clk);
      KEY = 4'hF;
      repeat (12) @(negedge clk);
      tests += 2;
      if (bus.a !== a0) begin fails++; $display("FAIL simul_addr: got %0d, required %0d", bus.a, a0); end
      if (ram[a0] !== ref_mem[a0]) begin
         fails++; $display("FAIL simul_data: got %02h, required %02h", ram[a0], ref_mem[a0]);
      end
      // KEY3 lands one cycle behind KEY1, so its pulse meets the RD state.
      @(negedge clk);
      KEY[1] = 1'b0;
      model_cmd(1);
      @(negedge clk);
      KEY[3] = 1'b0;
      repeat (12) @(negedge clk);
      KEY = 4'hF;
      repeat (12) @(negedge clk);
      tests += 2;
      if (bus.a !== a0) begin fails++; $display("FAIL busy_drop_addr: got %0d, required %0d", bus.a, a0); end
      if (ram[a0] !== ref_mem[a0]) begin
         fails++; $display("FAIL busy_drop_data: got %02h, required %02h", ram[a0], ref_mem[a0]);
      end
   endtask

   task automatic test_reset_in_wr();
      logic [AW-1:0] a0;
      a0 = ref_a;
      @(negedge clk);
      KEY[1] = 1'b0;
      model_cmd(1);
      repeat (WE_EDGE) @(negedge clk);
      tests++;
      if (bus.we !== 1'b1) begin fails++; $display("FAIL rst_wr_we_before: got %b, required 1", bus.we); end
      reset = 1'b1;
      KEY   = 4'hF;
      @(negedge clk);
      tests += 6;
      if (bus.we !== 1'b0)   begin fails++; $display("FAIL rst_wr_we: got %b, required 0", bus.we); end
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_wr_busy: got %b, required 0", bus.busy); end
      if (bus.a !== 4'd0)    begin fails++; $display("FAIL rst_wr_a: got %0d, required 0", bus.a); end
      if (bus.din !== 8'd0)  begin fails++; $display("FAIL rst_wr_din: got %02h, required 00", bus.din); end
      if (dbg_state !== IDLE) begin fails++; $display("FAIL rst_wr_state: got %0d, required IDLE", dbg_state); end
      if (ram[a0] !== ref_mem[a0]) begin
         fails++; $display("FAIL rst_wr_mem: got %02h, required %02h", ram[a0], ref_mem[a0]);
      end
      reset = 1'b0;
      ref_a = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom_range(0, 255)));
      do_reset();
      for (int n = 0; n < 24; n++) press(int'($urandom_range(0, 3)), int'($urandom_range(6, 14)));
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (ram[i] !== ref_mem[i]) begin
            fails++; $display("FAIL random_mem[%0d]: got %02h, required %02h", i, ram[i], ref_mem[i]);
         end
      end
      tests += 2;
      if (bus.a !== ref_a) begin fails++; $display("FAIL random_addr: got %0d, required %0d", bus.a, ref_a); end
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL random_pending_writes: got %0d outstanding, required 0", exp_q.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      for (int i = 0; i < 16; i++) preload(AW'(i), 8'h00);
      test_reset();
      test_addr_inc();
      test_addr_wrap();
      test_data();
      test_bounce();
      test_simultaneous();
      test_reset_in_wr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
